// File: rtl/fpu_bus_sequencer.sv
// Bus master for the memory-mapped FPU: turns one op request into the 8-bit
// write/poll/read sequence and returns the 32-bit result on a valid/ready port.
module fpu_bus_sequencer #(
  parameter int START_DLY = 2,
  parameter int POLL_MAX  = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_div,
  input  logic [31:0] req_y,
  input  logic [31:0] req_x,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_timeout,
  output logic        fpu_sel,
  output logic [1:0]  fpu_addr,
  output logic        fpu_read,
  output logic        fpu_write,
  output logic [7:0]  fpu_wdata,
  input  logic [7:0]  fpu_rdata
);

  typedef enum logic [3:0] {
    S_IDLE, S_WR, S_WGAP, S_DLY, S_POLL, S_PGAP, S_RD, S_RGAP, S_RESP
  } state_t;

  localparam logic [7:0] LP_DLY  = 8'((START_DLY >= 2) ? START_DLY - 2 : 0);
  localparam logic [7:0] LP_PMAX = 8'(POLL_MAX);

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [7:0]  r_poll;
  logic        r_busy;
  logic        r_div;
  logic [31:0] r_y, r_x;
  logic        r_rsp_valid;
  logic [31:0] r_result;
  logic        r_timeout;
  logic        r_sel, r_rd, r_wr;
  logic [1:0]  r_addr;
  logic [7:0]  r_wdata;
  logic [3:0]  w_nidx;

  // Write slot k of the 11-write sequence: command bytes sit in slots 0, 5 and 10.
  function automatic logic [7:0] f_wbyte(input logic [3:0] idx, input logic [31:0] y,
                                         input logic [31:0] x, input logic dv);
    case (idx)
      4'd0:    return 8'h01;
      4'd1:    return y[31:24];
      4'd2:    return y[23:16];
      4'd3:    return y[15:8];
      4'd4:    return y[7:0];
      4'd5:    return 8'h02;
      4'd6:    return x[31:24];
      4'd7:    return x[23:16];
      4'd8:    return x[15:8];
      4'd9:    return x[7:0];
      default: return dv ? 8'h03 : 8'h04;
    endcase
  endfunction

  assign w_nidx = r_cnt[3:0] + 4'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_poll      <= '0;
      r_busy      <= 1'b0;
      r_div       <= 1'b0;
      r_y         <= '0;
      r_x         <= '0;
      r_rsp_valid <= 1'b0;
      r_result    <= '0;
      r_timeout   <= 1'b0;
      r_sel       <= 1'b0;
      r_rd        <= 1'b0;
      r_wr        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
    end else begin
      // Strobes last one cycle; address and data return to zero with them.
      r_sel   <= 1'b0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      case (r_state)
        S_IDLE: if (req_valid) begin
          r_y       <= req_y;
          r_x       <= req_x;
          r_div     <= req_div;
          r_cnt     <= '0;
          r_poll    <= '0;
          r_result  <= '0;
          r_timeout <= 1'b0;
          r_sel     <= 1'b1;
          r_wr      <= 1'b1;
          r_addr    <= 2'd2;
          r_wdata   <= 8'h01;
          r_state   <= S_WR;
        end
        S_WR: r_state <= S_WGAP;
        S_WGAP: begin
          if (r_cnt[3:0] == 4'd10) begin
            if (START_DLY <= 1) begin
              r_sel   <= 1'b1;
              r_rd    <= 1'b1;
              r_state <= S_POLL;
            end else begin
              r_cnt   <= LP_DLY;
              r_state <= S_DLY;
            end
          end else begin
            r_cnt   <= r_cnt + 8'd1;
            r_sel   <= 1'b1;
            r_wr    <= 1'b1;
            r_addr  <= (w_nidx == 4'd5 || w_nidx == 4'd10) ? 2'd2 : 2'd3;
            r_wdata <= f_wbyte(w_nidx, r_y, r_x, r_div);
            r_state <= S_WR;
          end
        end
        S_DLY: begin
          if (r_cnt == 8'd0) begin
            r_sel   <= 1'b1;
            r_rd    <= 1'b1;
            r_state <= S_POLL;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        S_POLL: begin
          r_busy  <= fpu_rdata[7];
          r_cnt   <= '0;
          r_state <= S_PGAP;
          if (fpu_rdata[7]) begin
            r_poll <= r_poll + 8'd1;
            if (r_poll + 8'd1 == LP_PMAX) r_timeout <= 1'b1;
          end
        end
        S_PGAP: begin
          if (r_timeout) begin
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end else begin
            r_sel   <= 1'b1;
            r_rd    <= 1'b1;
            r_addr  <= r_busy ? 2'd0 : 2'd1;
            r_state <= r_busy ? S_POLL : S_RD;
          end
        end
        S_RD: begin
          r_result <= {r_result[23:0], fpu_rdata};
          r_cnt    <= r_cnt + 8'd1;
          r_state  <= S_RGAP;
        end
        S_RGAP: begin
          if (r_cnt == 8'd4) begin
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end else begin
            r_sel   <= 1'b1;
            r_rd    <= 1'b1;
            r_addr  <= 2'd1;
            r_state <= S_RD;
          end
        end
        S_RESP: if (rsp_ready) begin
          r_rsp_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready   = (r_state == S_IDLE) && !reset;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_result  = r_result;
  assign rsp_timeout = r_timeout;
  assign fpu_sel     = r_sel;
  assign fpu_addr    = r_addr;
  assign fpu_read    = r_rd;
  assign fpu_write   = r_wr;
  assign fpu_wdata   = r_wdata;

endmodule

// File: tb/tb_fpu_bus_sequencer.sv
// Directed bench for fpu_bus_sequencer: a small FPU bus model, a bus monitor
// and hand-computed expectations for trace, timing and result.
module tb_fpu_bus_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0, req_div = 1'b0, rsp_ready = 1'b0;
  logic [31:0] req_y = '0, req_x = '0;
  logic        req_ready, rsp_valid, rsp_timeout, fpu_sel, fpu_read, fpu_write;
  logic [31:0] rsp_result;
  logic [1:0]  fpu_addr;
  logic [7:0]  fpu_wdata, fpu_rdata;

  logic        p4_req_valid = 1'b0, p4_rsp_ready = 1'b0;
  logic        p4_req_ready, p4_rsp_valid, p4_rsp_timeout, p4_sel, p4_read, p4_write;
  logic [31:0] p4_rsp_result;
  logic [1:0]  p4_addr;
  logic [7:0]  p4_wdata;
  logic [7:0]  p4_rdata;
  assign p4_rdata = 8'h80;

  fpu_bus_sequencer u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_div(req_div), .req_y(req_y), .req_x(req_x), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_timeout(rsp_timeout),
    .fpu_sel(fpu_sel), .fpu_addr(fpu_addr), .fpu_read(fpu_read), .fpu_write(fpu_write),
    .fpu_wdata(fpu_wdata), .fpu_rdata(fpu_rdata));

  fpu_bus_sequencer #(.START_DLY(2), .POLL_MAX(4)) u_dut4 (
    .clk(clk), .reset(reset), .req_valid(p4_req_valid), .req_ready(p4_req_ready),
    .req_div(req_div), .req_y(req_y), .req_x(req_x), .rsp_valid(p4_rsp_valid),
    .rsp_ready(p4_rsp_ready), .rsp_result(p4_rsp_result), .rsp_timeout(p4_rsp_timeout),
    .fpu_sel(p4_sel), .fpu_addr(p4_addr), .fpu_read(p4_read), .fpu_write(p4_write),
    .fpu_wdata(p4_wdata), .fpu_rdata(p4_rdata));

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // FPU model: busy for busy_cfg status reads after each accept, then result bytes MSB first
  int          busy_cfg = 0;
  logic [31:0] mdl_res = '0;
  int          busy_left = 0, rdidx = 0;
  always @(posedge clk) begin
    if (req_valid && req_ready) begin
      busy_left <= busy_cfg;
      rdidx     <= 0;
    end else begin
      if (fpu_read && fpu_addr == 2'd0 && busy_left > 0) busy_left <= busy_left - 1;
      if (fpu_read && fpu_addr == 2'd1) rdidx <= rdidx + 1;
    end
  end
  assign fpu_rdata = (fpu_addr == 2'd1) ? 8'(mdl_res >> (8 * (3 - rdidx)))
                                        : ((busy_left != 0) ? 8'h80 : 8'h00);

  int         cyc = 0;
  logic [9:0] wlog [16];
  int         wc [16];
  int         nwr = 0, nst = 0, nrd = 0, acc_cyc = 0, rv_cyc = -1, first_st = -1, last_st = -1;
  int         st4 = 0, rd4 = 0, viol = 0;
  logic       prev_stb = 1'b0, prev_stb4 = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (req_valid && req_ready) begin
      nwr = 0; nst = 0; nrd = 0; acc_cyc = cyc; rv_cyc = -1; first_st = -1; last_st = -1;
    end else begin
      if (fpu_write && nwr < 16) begin
        wlog[nwr] = {fpu_addr, fpu_wdata};
        wc[nwr] = cyc;
        nwr++;
      end
      if (fpu_read && fpu_addr == 2'd0) begin
        if (first_st < 0) first_st = cyc;
        last_st = cyc;
        nst++;
      end
      if (fpu_read && fpu_addr == 2'd1) nrd++;
      if (rsp_valid && rv_cyc < 0) rv_cyc = cyc;
    end
    if (p4_req_valid && p4_req_ready) begin
      st4 = 0; rd4 = 0;
    end else begin
      if (p4_read && p4_addr == 2'd0) st4++;
      if (p4_read && p4_addr == 2'd1) rd4++;
    end
    if ((fpu_read || fpu_write) && prev_stb) viol++;
    if (fpu_read && fpu_write) viol++;
    if (fpu_sel !== (fpu_read | fpu_write)) viol++;
    if (!(fpu_read || fpu_write) && (fpu_addr != 2'd0 || fpu_wdata != 8'd0)) viol++;
    if ((p4_read || p4_write) && prev_stb4) viol++;
    if (p4_read && p4_write) viol++;
    if (p4_sel !== (p4_read | p4_write)) viol++;
    prev_stb  = fpu_read | fpu_write;
    prev_stb4 = p4_read | p4_write;
  end

  task automatic start_req(input logic dv, input logic [31:0] y, input logic [31:0] x);
    @(posedge clk); #1;
    req_div = dv; req_y = y; req_x = x; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (rsp_valid) break;
    end
    #1;
    if (!rsp_valid) chk("rsp_wait", 0, 1);
  endtask

  task automatic ack_rsp();
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("ack_valid", rsp_valid, 0);
    chk("ack_ready", req_ready, 1);
  endtask

  logic [9:0]  t1_w [11];
  logic [31:0] h_res;
  logic        h_to;
  int          h_bad, h_bus;

  initial begin
    t1_w = '{10'h201, 10'h340, 10'h300, 10'h300, 10'h300, 10'h202,
             10'h340, 10'h340, 10'h300, 10'h300, 10'h204};
    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out", {fpu_sel, fpu_read, fpu_write, fpu_addr, fpu_wdata, rsp_valid, rsp_timeout, rsp_result}, 0);
    chk("rst_ready", req_ready, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", req_ready, 1);

    // 1: multiply, FPU never busy
    busy_cfg = 0; mdl_res = 32'h40C00000;
    start_req(1'b0, 32'h40000000, 32'h40400000);
    wait_rsp();
    chk("t1_nwr", nwr, 11);
    for (int i = 0; i < 11; i++) begin
      chk("t1_wr", wlog[i], t1_w[i]);
      chk("t1_wcyc", wc[i] - acc_cyc, 2 * i + 1);
    end
    chk("t1_nst", nst, 1);
    chk("t1_first_st", first_st - acc_cyc, 24);
    chk("t1_nrd", nrd, 4);
    chk("t1_res", rsp_result, 32'h40C00000);
    chk("t1_to", rsp_timeout, 0);
    chk("t1_lat", rv_cyc - acc_cyc, 34);
    ack_rsp();

    // 2: divide, busy for 5 polls
    busy_cfg = 5; mdl_res = 32'h40A00000;
    start_req(1'b1, 32'h41200000, 32'h40000000);
    wait_rsp();
    chk("t2_cmd", wlog[10], 10'h203);
    chk("t2_nst", nst, 6);
    chk("t2_st_span", last_st - first_st, 10);
    chk("t2_nrd", nrd, 4);
    chk("t2_res", rsp_result, 32'h40A00000);
    chk("t2_to", rsp_timeout, 0);
    chk("t2_lat", rv_cyc - acc_cyc, 44);
    ack_rsp();

    // 3: POLL_MAX=4 instance, FPU busy forever
    @(posedge clk); #1;
    p4_req_valid = 1'b1;
    @(posedge clk); #1;
    p4_req_valid = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (p4_rsp_valid) break;
    end
    #1;
    chk("t3_valid", p4_rsp_valid, 1);
    chk("t3_nst", st4, 4);
    chk("t3_nrd", rd4, 0);
    chk("t3_to", p4_rsp_timeout, 1);
    chk("t3_res", p4_rsp_result, 0);
    @(posedge clk); #1;
    p4_rsp_ready = 1'b1;
    @(posedge clk); #1;
    p4_rsp_ready = 1'b0;
    chk("t3_idle", p4_req_ready, 1);

    // 4: response held 10 cycles while req_valid is pulsed
    busy_cfg = 1; mdl_res = 32'h3F800000;
    start_req(1'b0, 32'h3F800000, 32'h3F800000);
    wait_rsp();
    h_res = rsp_result; h_to = rsp_timeout; h_bad = 0; h_bus = nwr + nst + nrd;
    chk("t4_res", rsp_result, 32'h3F800000);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      req_valid = (i == 3 || i == 4);
      req_y = 32'hDEADBEEF;
      @(negedge clk);
      if (!rsp_valid || rsp_result !== h_res || rsp_timeout !== h_to || req_ready) h_bad++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("t4_hold", h_bad, 0);
    chk("t4_nobus", nwr + nst + nrd, h_bus);
    ack_rsp();

    // 5: reset during the 3rd Y-byte write, then a full divide
    busy_cfg = 0; mdl_res = 32'h40000000;
    start_req(1'b1, 32'h40C00000, 32'h40400000);
    repeat (6) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("t5_pre_wr", {fpu_write, fpu_addr, fpu_wdata}, {1'b1, 2'd3, 8'h00});
    @(negedge clk);
    chk("t5_strobes", {fpu_sel, fpu_read, fpu_write}, 0);
    chk("t5_nwr", nwr, 4);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("t5_idle", req_ready, 1);
    busy_cfg = 2;
    start_req(1'b1, 32'h40C00000, 32'h40400000);
    wait_rsp();
    chk("t5_first_wr", wlog[0], 10'h201);
    chk("t5_nwr2", nwr, 11);
    chk("t5_cmd", wlog[10], 10'h203);
    chk("t5_res", rsp_result, 32'h40000000);
    ack_rsp();

    // 6: bus protocol over the whole run
    chk("proto", viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
